// File: rtl/axi4lite_sram_slave_pkg.sv
// Shared response codes, FSM state encodings and the address window decode
// used by the AXI4-lite SRAM responder.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    // Widened to 64 bits so base + window never wraps for any legal address width.
    function automatic logic addr_hit(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] depth_words);
        logic [63:0] span;
        span = depth_words << 2;
        return (addr >= base) && ((addr - base) < span);
    endfunction

endpackage

// File: rtl/axi4lite_sram_slave_if.sv
// AXI4-lite signal bundle between the core's master port and the SRAM responder.
interface axi4lite_sram_slave_if #(
    parameter int ADDR_WIDTH = 32
);
    // A transfer happens on a rising edge where valid && ready; valid, once
    // raised, holds with its payload stable until that edge.
    logic                  aw_valid;
    logic                  aw_ready;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic                  w_valid;
    logic                  w_ready;
    logic [31:0]           w_data;
    logic [3:0]            w_strb;
    logic                  b_valid;
    logic                  b_ready;
    logic [1:0]            b_resp;
    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic                  r_valid;
    logic                  r_ready;
    logic [31:0]           r_data;
    logic [1:0]            r_resp;

    modport master (
        output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

endinterface

// File: rtl/axi4lite_sram_slave_array.sv
// Word-addressed 1W/1R SRAM with byte enables and a registered read port that
// returns the pre-write word when read and write hit the same address.
module axi4lite_sram_array #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wbe,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi4lite_sram_slave.sv
// AXI4-lite responder backed by an on-chip SRAM: independent write (AW/W/B) and
// read (AR/R) engines, byte strobes, DECERR outside the address window.
module axi4lite_sram_slave
    import axi4lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    axi4lite_sram_slave_if.slave bus,
    output wr_state_e            wr_state,
    output rd_state_e            rd_state
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int STRB_W = DATA_WIDTH / 8;

    function automatic logic hit_of(input logic [ADDR_WIDTH-1:0] a);
        return addr_hit(64'(a), 64'(BASE_ADDR), 64'(DEPTH_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    // Readies stay low through reset and rise one cycle after it is released.
    logic live;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;

    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic [1:0]            b_resp_q;
    logic [1:0]            r_resp_q;
    logic                  rd_hit_q;

    logic                  aw_ready, w_ready, b_valid;
    logic                  ar_ready, r_valid;
    logic                  latch_aw, latch_w, commit, rd_start;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_data;
    logic [STRB_W-1:0]     c_strb;
    logic                  c_hit, ar_hit;
    logic [31:0]           arr_rdata;

    assign c_hit  = hit_of(c_addr);
    assign ar_hit = hit_of(bus.ar_addr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            live       <= 1'b0;
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
        end else begin
            live       <= 1'b1;
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        aw_ready   = 1'b0;
        w_ready    = 1'b0;
        b_valid    = 1'b0;
        latch_aw   = 1'b0;
        latch_w    = 1'b0;
        commit     = 1'b0;
        c_addr     = bus.aw_addr;
        c_data     = bus.w_data;
        c_strb     = bus.w_strb;
        case (wr_state_q)
            W_IDLE: begin
                aw_ready = live;
                w_ready  = live;
                if (live && bus.aw_valid && bus.w_valid) begin
                    commit     = 1'b1;
                    wr_state_d = W_RESP;
                end else if (live && bus.aw_valid) begin
                    latch_aw   = 1'b1;
                    wr_state_d = W_HAVE_AW;
                end else if (live && bus.w_valid) begin
                    latch_w    = 1'b1;
                    wr_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                w_ready = live;
                c_addr  = aw_addr_q;
                if (live && bus.w_valid) begin
                    commit     = 1'b1;
                    wr_state_d = W_RESP;
                end
            end
            W_HAVE_W: begin
                aw_ready = live;
                c_data   = w_data_q;
                c_strb   = w_strb_q;
                if (live && bus.aw_valid) begin
                    commit     = 1'b1;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (bus.b_ready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_resp_q  <= RESP_OKAY;
        end else begin
            if (latch_aw) aw_addr_q <= bus.aw_addr;
            if (latch_w) begin
                w_data_q <= bus.w_data;
                w_strb_q <= bus.w_strb;
            end
            if (commit) b_resp_q <= c_hit ? RESP_OKAY : RESP_DECERR;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        ar_ready   = 1'b0;
        r_valid    = 1'b0;
        rd_start   = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                ar_ready = live;
                if (live && bus.ar_valid) begin
                    rd_start   = 1'b1;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                r_valid = 1'b1;
                if (bus.r_ready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_hit_q <= 1'b0;
            r_resp_q <= RESP_OKAY;
        end else if (rd_start) begin
            rd_hit_q <= ar_hit;
            r_resp_q <= ar_hit ? RESP_OKAY : RESP_DECERR;
        end
    end

    // The array holds its output between reads, so r_data stays stable under backpressure.
    axi4lite_sram_array #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk_i),
        .we    (commit && c_hit && !rst_i),
        .waddr (idx_of(c_addr)),
        .wdata (c_data),
        .wbe   (c_strb),
        .re    (rd_start && ar_hit && !rst_i),
        .raddr (idx_of(bus.ar_addr)),
        .rdata (arr_rdata)
    );

    assign bus.aw_ready = aw_ready;
    assign bus.w_ready  = w_ready;
    assign bus.b_valid  = b_valid;
    assign bus.b_resp   = b_resp_q;
    assign bus.ar_ready = ar_ready;
    assign bus.r_valid  = r_valid;
    assign bus.r_resp   = r_resp_q;
    assign bus.r_data   = (rd_state_q == R_DATA && rd_hit_q) ? arr_rdata : 32'h0;

    assign wr_state = wr_state_q;
    assign rd_state = rd_state_q;

endmodule
